store_buffer: RTL and testbench
===============================

# store_buffer

Four-entry posted store buffer between the MEM pipeline stage and the byte-addressed, big-endian data memory. Accepts word, halfword and byte stores in one cycle, then drains them in order to the memory write port whenever loads leave the port free. Loads pass straight through to the memory. A load that overlaps any pending store is stalled until the conflicting entries have drained, so load results always reflect program order.

## Interface
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- ADDR_W, 32, byte address width.
- clk  in  1  the single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- st_valid  in  1  store request from the MEM stage.
- st_address  in  ADDR_W  byte address of the store (address of the MSB byte).
- st_data  in  32  store data; only the low 16 or 8 bits are used for halfword or byte stores.
- st_size  in  2  access size: 11 = word, 10 = halfword, 01 = byte, 00 = no access.
- st_ready  out  1  asserted when count < DEPTH; a store is accepted when st_valid && st_ready.
- ld_valid  in  1  load request from the MEM stage.
- ld_address  in  ADDR_W  byte address of the load.
- ld_size  in  2  size of the load, using the same encoding as st_size.
- ld_stall  out  1  the load conflicts with a pending store; the pipeline must hold the load.
- mem_address  out  ADDR_W  address to the data memory.
- mem_write_data  out  32  write data to the data memory.
- mem_size  out  2  access size to the data memory.
- mem_write  out  1  write strobe to the data memory.
- mem_read  out  1  read strobe to the data memory.
- empty  out  1  asserted when count == 0.
- count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage is a circular FIFO. Each entry holds {address, data, size}. Head and tail pointers wrap modulo DEPTH.
- Enqueue happens when st_valid && st_ready && st_size != 00. An accepted store with st_size == 00 is consumed but not stored.
- Byte length of an access is 4 for word, 2 for halfword, 1 for byte.
- Two accesses A and B overlap when A.addr < B.addr + B.len and B.addr < A.addr + A.len. The comparison is done in ADDR_W+1 bits, so the range never wraps.
- ld_stall = ld_valid && ld_size != 00 && (the load overlaps any valid entry). This is combinational.
- A store presented in the same cycle as the load is not part of the overlap check; the store is treated as younger than the load.
- Port arbitration (combinational):
  - If ld_valid && !ld_stall, the load owns the port: mem_read = 1, mem_address = ld_address, mem_size = ld_size, mem_write = 0.
  - Otherwise, if !empty, the head entry drains: mem_write = 1, mem_address/mem_write_data/mem_size come from the head entry, mem_read = 0. The head pops at the next rising edge.
  - Otherwise mem_read = 0, mem_write = 0, and mem_size = 00.
- A stalled load never blocks draining. The buffer therefore drains until the conflict clears, then the load proceeds.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance. When full, st_ready is 0 in that cycle even if a dequeue is happening; there is no same-cycle pass-through.

## Timing
- Reset values: count = 0, head = tail = 0, empty = 1, st_ready = 1, mem_write = 0, mem_read = 0, ld_stall = 0, mem_size = 00.
- A reset during draining discards all pending stores. The write already presented in that cycle still reaches the memory; the memory samples it on the falling edge of clk.
- Store latency: a store accepted at edge T is on the memory port in cycle T+1 at the earliest.
- Throughput: one store in and one store out per cycle.
- Worst-case stall for a conflicting load is DEPTH cycles when no other loads intervene.
- The memory write occurs on the falling edge within the drain cycle. The pop is on the following rising edge, so the data is visible to a load in the next cycle.

## Structure
- Package mem_pkg holds:
  - the size constants WORD = 2'b11, HALFWORD = 2'b10, BYTE = 2'b01, NONE = 2'b00;
  - the function byte_len(size);
  - the entry struct type.
- Sub-module range_overlap computes the overlap test for one access pair. It is instantiated DEPTH times, with each result gated by that entry's valid bit.

## Test plan
- Reset, then store word 0x01234567 @4 and halfword 0x4567 @10 with no loads. Expect mem_write in cycles T+1 and T+2 with matching address, data and size, and count returning to 0.
- Five back-to-back stores with ld_valid held high to non-overlapping address 64. Expect st_ready = 0 after the 4th store, no mem_write while the load owns the port, and draining once ld_valid drops.
- Pending byte store @13, then load word @12. Expect ld_stall = 1 and mem_write @13 in the same cycle. Next cycle expect ld_stall = 0 and mem_read @12.
- Pending word store @4, then load byte @8 (boundary case, no overlap). Expect ld_stall = 0 and mem_read immediately.
- Simultaneous enqueue and dequeue at count = 3. Expect count to stay at 3 and the pointers to wrap correctly across 4 or more cycles.
- Assert reset with 3 entries pending. Expect count = 0, empty = 1 and no further mem_write after the reset cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory side of the MEM stage: access size
// encodings, their byte lengths, and the store-buffer entry layout.
package mem_pkg;

  localparam logic [1:0] WORD     = 2'b11;
  localparam logic [1:0] HALFWORD = 2'b10;
  localparam logic [1:0] BYTE     = 2'b01;
  localparam logic [1:0] NONE     = 2'b00;

  // Widest byte address an entry can hold; narrower buses zero-extend into it.
  localparam int MAX_ADDR_W = 64;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [1:0]            size;
  } entry_t;

  function automatic logic [2:0] byte_len(input logic [1:0] size);
    case (size)
      WORD:     return 3'd4;
      HALFWORD: return 3'd2;
      BYTE:     return 3'd1;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/range_overlap.sv
// Byte-range intersection test for two accesses, evaluated one bit wider than
// the address so a range ending at the top of the address space never wraps.
module range_overlap
  import mem_pkg::*;
#(
  parameter int AW = MAX_ADDR_W
) (
  input  logic [AW-1:0] a_addr_i,
  input  logic [1:0]    a_size_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [1:0]    b_size_i,
  output logic          overlap_o
);

  localparam int EW = AW + 1;

  logic [EW-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = {1'b0, a_addr_i};
  assign b_lo = {1'b0, b_addr_i};
  assign a_hi = a_lo + EW'(byte_len(a_size_i));
  assign b_hi = b_lo + EW'(byte_len(b_size_i));

  assign overlap_o = (a_lo < b_hi) && (b_lo < a_hi);

endmodule

// File: rtl/store_buffer.sv
// Posted store buffer: stores enter a circular FIFO and drain in order to the
// memory port whenever no load needs it; loads hitting a pending store stall.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_address,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_address,
  input  logic [1:0]               ld_size,
  output logic                     ld_stall,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [31:0]              mem_write_data,
  output logic [1:0]               mem_size,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          entries_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] hit;
  logic            push, pop, load_go;
  entry_t          head_e, new_e;

  assign st_ready = count_q < CW'(DEPTH);
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // An entry is live when its distance from the head is below the fill count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic [PW-1:0] offset;
    logic          ovl;

    assign offset = PW'(gi) - head_q;

    range_overlap #(.AW(MAX_ADDR_W)) u_overlap (
      .a_addr_i  (entries_q[gi].addr),
      .a_size_i  (entries_q[gi].size),
      .b_addr_i  (MAX_ADDR_W'(ld_address)),
      .b_size_i  (ld_size),
      .overlap_o (ovl)
    );

    assign hit[gi] = ovl && ({1'b0, offset} < count_q);
  end

  assign ld_stall = ld_valid && (ld_size != NONE) && (|hit);
  assign load_go  = ld_valid && !ld_stall;
  assign pop      = !load_go && !empty;
  assign push     = st_valid && st_ready && (st_size != NONE);

  assign head_e = entries_q[head_q];
  assign new_e  = '{addr: MAX_ADDR_W'(st_address), data: st_data, size: st_size};

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_size       = NONE;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (load_go) begin
      mem_read    = 1'b1;
      mem_address = ld_address;
      mem_size    = ld_size;
    end else if (pop) begin
      mem_write      = 1'b1;
      mem_address    = head_e.addr[ADDR_W-1:0];
      mem_write_data = head_e.data;
      mem_size       = head_e.size;
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: liveness comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= new_e;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the buffer.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   st_valid;
  logic [ADDR_W-1:0]      st_address;
  logic [31:0]            st_data;
  logic [1:0]             st_size;
  logic                   st_ready;
  logic                   ld_valid;
  logic [ADDR_W-1:0]      ld_address;
  logic [1:0]             ld_size;
  logic                   ld_stall;
  logic [ADDR_W-1:0]      mem_address;
  logic [31:0]            mem_write_data;
  logic [1:0]             mem_size;
  logic                   mem_write;
  logic                   mem_read;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .st_valid       (st_valid),
    .st_address     (st_address),
    .st_data        (st_data),
    .st_size        (st_size),
    .st_ready       (st_ready),
    .ld_valid       (ld_valid),
    .ld_address     (ld_address),
    .ld_size        (ld_size),
    .ld_stall       (ld_stall),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_size       (mem_size),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .empty          (empty),
    .count          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned addr;
    logic [31:0]     data;
    logic [1:0]      size;
  } st_t;

  st_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int blen(input logic [1:0] s);
    case (s)
      2'b11:   return 4;
      2'b10:   return 2;
      2'b01:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit touches(input longint unsigned a, input int la,
                                 input longint unsigned b, input int lb);
    return (a < b + longint'(lb)) && (b < a + longint'(la));
  endfunction

  function automatic logic [31:0] dmask(input logic [1:0] s);
    case (s)
      2'b11:   return 32'hFFFF_FFFF;
      2'b10:   return 32'h0000_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic cycle(input bit chk, input bit rst,
                       input bit sv, input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] ss,
                       input bit lv, input logic [31:0] la, input logic [1:0] ls);
    bit stall_e, go_e, ready_e;
    @(posedge clk);
    #1;
    reset = rst; st_valid = sv; st_address = sa; st_data = sd; st_size = ss;
    ld_valid = lv; ld_address = la; ld_size = ls;
    @(negedge clk);
    ready_e = q.size() < DEPTH;
    stall_e = 1'b0;
    if (lv && ls != 2'b00)
      foreach (q[i]) if (touches(q[i].addr, blen(q[i].size), longint'(la), blen(ls))) stall_e = 1'b1;
    go_e = lv && !stall_e;
    if (chk) begin
      check("count", 64'(count), 64'(q.size()));
      check("empty", 64'(empty), 64'(q.size() == 0));
      check("st_ready", 64'(st_ready), 64'(ready_e));
      check("ld_stall", 64'(ld_stall), 64'(stall_e));
      if (go_e) begin
        check("rd_strobe", 64'(mem_read), 64'd1);
        check("rd_nowrite", 64'(mem_write), 64'd0);
        check("rd_addr", 64'(mem_address), 64'(la));
        check("rd_size", 64'(mem_size), 64'(ls));
      end else if (q.size() > 0) begin
        check("wr_strobe", 64'(mem_write), 64'd1);
        check("wr_noread", 64'(mem_read), 64'd0);
        check("wr_addr", 64'(mem_address), 64'(q[0].addr));
        check("wr_size", 64'(mem_size), 64'(q[0].size));
        check("wr_data", 64'(mem_write_data & dmask(q[0].size)), 64'(q[0].data & dmask(q[0].size)));
      end else begin
        check("idle_read", 64'(mem_read), 64'd0);
        check("idle_write", 64'(mem_write), 64'd0);
        check("idle_size", 64'(mem_size), 64'd0);
      end
    end
    if (rst) begin
      q.delete();
    end else begin
      if (go_e) $display("load  @%08h size %b", la, ls);
      if (!go_e && q.size() > 0) begin
        $display("drain @%08h size %b data %08h", q[0].addr[31:0], q[0].size, q[0].data);
        q.delete(0);
      end
      if (sv && ready_e && ss != 2'b00) begin
        $display("store @%08h size %b data %08h", sa, ss, sd);
        q.push_back('{addr: longint'(sa), data: sd, size: ss});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_address = '0; st_data = '0; st_size = 2'b00;
    ld_valid = 1'b0; ld_address = '0; ld_size = 2'b00;

    cycle(0, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    cycle(1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    check("reset_count", 64'(count), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);

    // Word then halfword, drained on consecutive cycles.
    cycle(1, 0, 1, 32'd4, 32'h0123_4567, 2'b11, 0, 0, 2'b00);
    check("no_same_cycle_write", 64'(mem_write), 64'd0);
    cycle(1, 0, 1, 32'd10, 32'h0000_4567, 2'b10, 0, 0, 2'b00);
    check("t1_addr", 64'(mem_address), 64'd4);
    check("t1_data", 64'(mem_write_data), 64'h0123_4567);
    idle(1);
    check("t2_addr", 64'(mem_address), 64'd10);
    check("t2_size", 64'(mem_size), 64'd2);
    idle(1);
    check("drained_count", 64'(count), 64'd0);

    // Five stores while an unrelated load holds the port.
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b11, 1, 32'd64, 2'b11);
    check("full_not_ready", 64'(st_ready), 64'd0);
    check("full_no_write", 64'(mem_write), 64'd0);
    idle(5);

    // Byte @13 blocks word load @12 until it drains.
    cycle(1, 0, 1, 32'd13, 32'h0000_00AB, 2'b01, 0, 0, 2'b00);
    cycle(1, 0, 0, 0, 0, 2'b00, 1, 32'd12, 2'b11);
    check("conflict_stall", 64'(ld_stall), 64'd1);
    check("conflict_drain_addr", 64'(mem_address), 64'd13);
    cycle(1, 0, 0, 0, 0, 2'b00, 1, 32'd12, 2'b11);
    check("conflict_cleared", 64'(ld_stall), 64'd0);
    check("conflict_read", 64'(mem_read), 64'd1);

    // Word @4 ends just below byte load @8.
    cycle(1, 0, 1, 32'd4, 32'hCAFE_F00D, 2'b11, 0, 0, 2'b00);
    cycle(1, 0, 0, 0, 0, 2'b00, 1, 32'd8, 2'b01);
    check("adjacent_no_stall", 64'(ld_stall), 64'd0);
    check("adjacent_read", 64'(mem_read), 64'd1);
    idle(2);

    // Build count 3, then push while draining so the pointers lap the ring.
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 1, 32'h200 + 32'(i), 32'(i), 2'b01, 1, 32'd64, 2'b11);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 1, 32'h300 + 32'(2 * i), 32'h5A00 + 32'(i), 2'b10, 0, 0, 2'b00);
      check("steady_count", 64'(count), 64'd3);
    end
    idle(4);

    // Reset with three stores pending.
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 1, 32'h400 + 32'(4 * i), 32'hBEEF_0000 + 32'(i), 2'b11, 1, 32'd64, 2'b11);
    cycle(1, 1, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    idle(1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_no_write", 64'(mem_write), 64'd0);

    // Halfword at the top of the address space must not wrap onto address 0.
    cycle(1, 0, 1, 32'hFFFF_FFFE, 32'h0000_1234, 2'b10, 1, 32'd64, 2'b11);
    cycle(1, 0, 0, 0, 0, 2'b00, 1, 32'd0, 2'b01);
    check("top_no_wrap", 64'(ld_stall), 64'd0);
    cycle(1, 0, 0, 0, 0, 2'b00, 1, 32'hFFFF_FFFF, 2'b01);
    check("top_overlap", 64'(ld_stall), 64'd1);
    idle(2);

    // Random traffic over a small address window to provoke overlaps.
    for (int n = 0; n < 600; n++) begin
      bit rst_r, sv_r, lv_r;
      logic [31:0] sa_r, la_r;
      rst_r = ($urandom_range(0, 63) == 0);
      sv_r  = ($urandom_range(0, 99) < 60);
      lv_r  = ($urandom_range(0, 99) < 45);
      sa_r  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                           : 32'($urandom_range(0, 31));
      la_r  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                           : 32'($urandom_range(0, 31));
      cycle(1, rst_r, sv_r, sa_r, $urandom, 2'($urandom_range(0, 3)),
            lv_r, la_r, 2'($urandom_range(0, 3)));
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
